// File: rtl/boot_streamer.sv
// Boot image streamer: parses a host word stream of {id, dcount, icount}
// headers followed by instruction and data words, and writes them into the
// boot memories of the selected mesh processor while the mesh is held in reset.
module boot_streamer #(
    parameter int GAP_CYCLES = 2,
    parameter int NUM_PROC   = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  processor_select,
    output logic        mesh_resetn,
    output logic [13:0] boot_iaddr,
    output logic [31:0] boot_idata,
    output logic [13:0] boot_daddr,
    output logic [31:0] boot_ddata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [3:0]       SEL_IDLE = 4'(NUM_PROC);
    localparam logic [3:0]       ID_END   = 4'hF;
    localparam int               GAP_W    = $clog2(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_HDR,
        ST_GAP,
        ST_INSTR,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               gap_to_hdr_q, gap_to_hdr_d;   // this gap closes a load
    logic [3:0]         pid_q, pid_d;
    logic [13:0]        icount_q, icount_d;
    logic [13:0]        dcount_q, dcount_d;
    logic               illegal_q, illegal_d;         // current load is discarded
    logic [13:0]        idx_q, idx_d;
    logic [3:0]         sel_q, sel_d;
    logic [13:0]        iaddr_q, iaddr_d;
    logic [31:0]        idata_q, idata_d;
    logic [13:0]        daddr_q, daddr_d;
    logic [31:0]        ddata_q, ddata_d;
    logic               err_q, err_d;
    logic               ready_en_q, ready_en_d;       // low for the reset cycle only

    logic               xfer;
    logic [3:0]         hdr_id;

    assign hdr_id = in_data[31:28];
    assign xfer   = in_valid & in_ready;

    // Handshake and status outputs decode straight from registered state.
    always_comb begin
        in_ready = ready_en_q &
                   ((state_q == ST_HDR) || (state_q == ST_INSTR) || (state_q == ST_DATA));
    end

    assign processor_select = sel_q;
    assign done             = (state_q == ST_DONE);
    assign busy             = ~done;
    assign mesh_resetn      = done;
    assign boot_iaddr       = iaddr_q;
    assign boot_idata       = idata_q;
    assign boot_daddr       = daddr_q;
    assign boot_ddata       = ddata_q;
    assign err              = err_q;

    // Next-state and next-output logic for the stream parser.
    always_comb begin
        // NOTE: every *_d starts from its *_q, so no branch leaves a value
        // unassigned -- this is what keeps the block free of inferred latches.
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        gap_to_hdr_d = gap_to_hdr_q;
        pid_d        = pid_q;
        icount_d     = icount_q;
        dcount_d     = dcount_q;
        illegal_d    = illegal_q;
        idx_d        = idx_q;
        sel_d        = sel_q;
        iaddr_d      = iaddr_q;
        idata_d      = idata_q;
        daddr_d      = daddr_q;
        ddata_d      = ddata_q;
        err_d        = err_q;
        ready_en_d   = 1'b1;

        case (state_q)
            ST_HDR: begin
                sel_d = SEL_IDLE;
                if (xfer) begin
                    if (hdr_id == ID_END) begin
                        state_d = ST_DONE;
                    end else begin
                        pid_d        = hdr_id;
                        dcount_d     = in_data[27:14];
                        icount_d     = in_data[13:0];
                        illegal_d    = (hdr_id >= SEL_IDLE);
                        err_d        = err_q | (hdr_id >= SEL_IDLE);
                        gap_cnt_d    = '0;
                        gap_to_hdr_d = 1'b0;
                        state_d      = ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                sel_d = SEL_IDLE;
                // First gap cycle still shows the last write; clear from the second on.
                if (gap_cnt_q == '0) begin
                    iaddr_d = '0;
                    idata_d = '0;
                    daddr_d = '0;
                    ddata_d = '0;
                end
                if (gap_cnt_q == GAP_LAST) begin
                    idx_d = '0;
                    if (gap_to_hdr_q) begin
                        state_d = ST_HDR;
                    end else if (icount_q != '0) begin
                        state_d = ST_INSTR;
                        sel_d   = illegal_q ? SEL_IDLE : pid_q;
                    end else if (dcount_q != '0) begin
                        state_d = ST_DATA;
                        sel_d   = illegal_q ? SEL_IDLE : pid_q;
                    end else begin
                        state_d = ST_HDR;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            ST_INSTR: begin
                if (xfer) begin
                    if (!illegal_q) begin
                        iaddr_d = idx_q;
                        idata_d = in_data;
                    end
                    if (idx_q == icount_q - 14'd1) begin
                        idx_d = '0;
                        if (dcount_q != '0) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d      = ST_GAP;
                            gap_cnt_d    = '0;
                            gap_to_hdr_d = 1'b1;
                            sel_d        = SEL_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 14'd1;
                    end
                end
            end

            ST_DATA: begin
                if (xfer) begin
                    if (!illegal_q) begin
                        daddr_d = idx_q;
                        ddata_d = in_data;
                    end
                    if (idx_q == dcount_q - 14'd1) begin
                        idx_d        = '0;
                        state_d      = ST_GAP;
                        gap_cnt_d    = '0;
                        gap_to_hdr_d = 1'b1;
                        sel_d        = SEL_IDLE;
                    end else begin
                        idx_d = idx_q + 14'd1;
                    end
                end
            end

            ST_DONE: begin
                sel_d = SEL_IDLE;
            end

            default: begin
                state_d = ST_HDR;
                sel_d   = SEL_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; a reset discards any partial image.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only, so every flop samples the
        // pre-edge value of the others regardless of statement order.
        if (reset) begin
            state_q      <= ST_HDR;
            gap_cnt_q    <= '0;
            gap_to_hdr_q <= 1'b0;
            pid_q        <= '0;
            icount_q     <= '0;
            dcount_q     <= '0;
            illegal_q    <= 1'b0;
            idx_q        <= '0;
            sel_q        <= SEL_IDLE;
            iaddr_q      <= '0;
            idata_q      <= '0;
            daddr_q      <= '0;
            ddata_q      <= '0;
            err_q        <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            gap_to_hdr_q <= gap_to_hdr_d;
            pid_q        <= pid_d;
            icount_q     <= icount_d;
            dcount_q     <= dcount_d;
            illegal_q    <= illegal_d;
            idx_q        <= idx_d;
            sel_q        <= sel_d;
            iaddr_q      <= iaddr_d;
            idata_q      <= idata_d;
            daddr_q      <= daddr_d;
            ddata_q      <= ddata_d;
            err_q        <= err_d;
            ready_en_q   <= ready_en_d;
        end
    end

endmodule

// File: tb/tb_boot_streamer.sv
// Testbench for boot_streamer: directed streams, a stream-level reference
// model checked every cycle, and literal expectations per scenario.
module tb_boot_streamer;

    localparam int         GAP = 2;
    localparam logic [3:0] NP  = 4'd9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  processor_select;
    logic        mesh_resetn;
    logic [13:0] boot_iaddr;
    logic [31:0] boot_idata;
    logic [13:0] boot_daddr;
    logic [31:0] boot_ddata;
    logic        busy;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    boot_streamer #(.GAP_CYCLES(GAP), .NUM_PROC(9)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .processor_select (processor_select),
        .mesh_resetn      (mesh_resetn),
        .boot_iaddr       (boot_iaddr),
        .boot_idata       (boot_idata),
        .boot_daddr       (boot_daddr),
        .boot_ddata       (boot_ddata),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [3:0] id, input int dc, input int ic);
        return {id, 14'(dc), 14'(ic)};
    endfunction

    // ---------------- stream-level reference model ----------------
    bit          rst_seen = 1'b1;
    bit          m_ready, m_err, m_done, m_legal;
    logic [3:0]  m_sel, m_pid;
    logic [13:0] m_iaddr, m_daddr;
    logic [31:0] m_idata, m_ddata;
    int          m_gap, m_ni, m_nd, m_iidx, m_didx;

    // observation logs for literal expectations
    logic [45:0] ilog[$];
    logic [45:0] dlog[$];
    logic [3:0]  sel_log[$];
    logic [3:0]  prev_sel = NP;
    logic [31:0] prev_idata = '0;
    logic [31:0] prev_ddata = '0;
    int          np_run = 0;
    int          min_np_run = 1000;
    bit          seen_id = 1'b0;

    always @(posedge clk) rst_seen <= reset;

    always @(negedge clk) begin
        if (rst_seen) begin
            check("rst_sel", processor_select, NP);
            check("rst_mesh_resetn", mesh_resetn, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_busy", busy, 1);
            check("rst_done", done, 0);
            check("rst_err", err, 0);
            check("rst_buses", {boot_iaddr, boot_idata, boot_daddr, boot_ddata}, 0);
            m_ready = 1'b1;  // valid from the first cycle after reset is released
            m_err = 0; m_done = 0; m_legal = 1;
            m_sel = NP; m_pid = 0;
            m_iaddr = 0; m_idata = 0; m_daddr = 0; m_ddata = 0;
            m_gap = 0; m_ni = 0; m_nd = 0; m_iidx = 0; m_didx = 0;
        end else begin
            check("sel", processor_select, m_sel);
            check("in_ready", in_ready, m_ready);
            check("done", done, m_done);
            check("busy", busy, !m_done);
            check("mesh_resetn", mesh_resetn, m_done);
            check("err", err, m_err);
            check("iaddr", boot_iaddr, m_iaddr);
            check("idata", boot_idata, m_idata);
            check("daddr", boot_daddr, m_daddr);
            check("ddata", boot_ddata, m_ddata);
            check("select_hop", (prev_sel != NP) && (processor_select != NP)
                                && (processor_select != prev_sel), 0);

            // expectations for the next cycle
            if (m_done) begin
                // everything holds until reset
            end else if (m_gap > 0) begin
                if (m_gap == GAP) begin
                    m_iaddr = 0; m_idata = 0; m_daddr = 0; m_ddata = 0;
                end
                m_gap--;
                if (m_gap == 0) begin
                    m_ready = 1'b1;
                    if ((m_ni != 0 || m_nd != 0) && m_legal) m_sel = m_pid;
                end
            end else if (in_valid && in_ready) begin
                if (m_ni == 0 && m_nd == 0) begin
                    if (in_data[31:28] == 4'hF) begin
                        m_done = 1'b1;
                        m_ready = 1'b0;
                    end else begin
                        m_pid   = in_data[31:28];
                        m_nd    = int'(in_data[27:14]);
                        m_ni    = int'(in_data[13:0]);
                        m_legal = (m_pid < NP);
                        if (!m_legal) m_err = 1'b1;
                        m_iidx = 0; m_didx = 0;
                        m_gap = GAP;
                        m_ready = 1'b0;
                    end
                end else if (m_ni > 0) begin
                    if (m_legal) begin m_iaddr = 14'(m_iidx); m_idata = in_data; end
                    m_iidx++; m_ni--;
                    if (m_ni == 0 && m_nd == 0) begin
                        m_gap = GAP; m_ready = 1'b0; m_sel = NP;
                    end
                end else begin
                    if (m_legal) begin m_daddr = 14'(m_didx); m_ddata = in_data; end
                    m_didx++; m_nd--;
                    if (m_nd == 0) begin
                        m_gap = GAP; m_ready = 1'b0; m_sel = NP;
                    end
                end
            end
        end

        // logging of observed writes and select changes
        if (boot_idata !== prev_idata && boot_idata !== 32'd0) ilog.push_back({boot_iaddr, boot_idata});
        if (boot_ddata !== prev_ddata && boot_ddata !== 32'd0) dlog.push_back({boot_daddr, boot_ddata});
        if (processor_select !== prev_sel) sel_log.push_back(processor_select);
        if (processor_select == NP) begin
            np_run++;
        end else begin
            if (processor_select != prev_sel && seen_id && np_run < min_np_run) min_np_run = np_run;
            seen_id = 1'b1;
            np_run = 0;
        end
        prev_idata = boot_idata;
        prev_ddata = boot_ddata;
        prev_sel   = processor_select;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        ilog.delete(); dlog.delete(); sel_log.delete();
        np_run = 0; min_np_run = 1000; seen_id = 1'b0;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_logs();
    endtask

    task automatic send(input logic [31:0] w, input bit bubble);
        int waited;
        if (bubble) begin in_valid = 1'b0; @(posedge clk); #1; end
        in_data = w;
        in_valid = 1'b1;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 64) begin @(posedge clk); #1; waited++; end
        check("handshake_ready", in_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;

        // Full load: id 0, three instructions, two data words, then end marker.
        apply_reset();
        send(hdr(4'd0, 2, 3), 0);
        send(32'h1111_000A, 0);
        send(32'h1111_000B, 0);
        send(32'h1111_000C, 0);
        send(32'h2222_0058, 0);
        send(32'h2222_0059, 0);
        send(hdr(4'hF, 0, 0), 0);
        idle(4);
        check("t1_ilog_n", ilog.size(), 3);
        if (ilog.size() == 3) begin
            check("t1_i0", ilog[0], {14'd0, 32'h1111_000A});
            check("t1_i1", ilog[1], {14'd1, 32'h1111_000B});
            check("t1_i2", ilog[2], {14'd2, 32'h1111_000C});
        end
        check("t1_dlog_n", dlog.size(), 2);
        if (dlog.size() == 2) begin
            check("t1_d0", dlog[0], {14'd0, 32'h2222_0058});
            check("t1_d1", dlog[1], {14'd1, 32'h2222_0059});
        end
        check("t1_sel_log", {sel_log.size() == 2 ? {sel_log[0], sel_log[1]} : 8'hEE}, {4'd0, 4'd9});
        check("t1_done", done, 1);
        check("t1_mesh_resetn", mesh_resetn, 1);
        check("t1_sel", processor_select, 9);
        check("t1_ready", in_ready, 0);

        // Two back-to-back loads for ids 4 and 5 must pass through the idle select.
        apply_reset();
        send(hdr(4'd4, 0, 1), 0);
        send(32'h0404_0001, 0);
        send(hdr(4'd5, 0, 1), 0);
        send(32'h0505_0001, 0);
        idle(6);
        check("t2_sel_n", sel_log.size(), 4);
        if (sel_log.size() == 4)
            check("t2_sel_seq", {sel_log[0], sel_log[1], sel_log[2], sel_log[3]}, 16'h4959);
        check("t2_min_gap", min_np_run >= 2, 1);

        // Empty load: no select change, no error, back to header.
        apply_reset();
        send(hdr(4'd2, 0, 0), 0);
        idle(5);
        check("t3_sel_n", sel_log.size(), 0);
        check("t3_err", err, 0);
        check("t3_ready", in_ready, 1);
        send(hdr(4'd1, 0, 1), 0);
        send(32'h0101_0077, 0);
        idle(5);
        check("t3_after", ilog.size() == 1 ? ilog[0] : 46'h0, {14'd0, 32'h0101_0077});

        // Illegal id is consumed silently with err set; next load is normal.
        apply_reset();
        send(hdr(4'd12, 1, 1), 0);
        send(32'hBAD0_0001, 0);
        send(32'hBAD0_0002, 0);
        idle(1);
        check("t4_err", err, 1);
        send(hdr(4'd3, 0, 1), 0);
        send(32'h0303_0001, 0);
        idle(5);
        check("t4_err_sticky", err, 1);
        check("t4_ilog_n", ilog.size(), 1);
        check("t4_dlog_n", dlog.size(), 0);
        if (ilog.size() == 1) check("t4_i0", ilog[0], {14'd0, 32'h0303_0001});
        check("t4_sel_seq", sel_log.size() == 2 ? {sel_log[0], sel_log[1]} : 8'hEE, 8'h39);

        // Stalls between instruction words; highest legal id.
        apply_reset();
        send(hdr(4'd8, 0, 4), 0);
        for (int i = 0; i < 4; i++) send(32'h0808_0010 + 32'(i), 1);
        idle(5);
        check("t5_ilog_n", ilog.size(), 4);
        if (ilog.size() == 4)
            for (int i = 0; i < 4; i++) check("t5_i", ilog[i], {14'(i), 32'h0808_0010 + 32'(i)});

        // Reset in the middle of an instruction load, then reload from address 0.
        apply_reset();
        send(hdr(4'd6, 0, 5), 0);
        send(32'h0606_0001, 0);
        send(32'h0606_0002, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_sel", processor_select, 9);
        check("t6_rst_ready", in_ready, 0);
        check("t6_rst_iaddr", boot_iaddr, 0);
        check("t6_rst_idata", boot_idata, 0);
        reset = 1'b0;
        clear_logs();
        send(hdr(4'd6, 0, 2), 0);
        send(32'h0606_00A1, 0);
        send(32'h0606_00A2, 0);
        idle(5);
        check("t6_ilog_n", ilog.size(), 2);
        if (ilog.size() == 2) begin
            check("t6_i0", ilog[0], {14'd0, 32'h0606_00A1});
            check("t6_i1", ilog[1], {14'd1, 32'h0606_00A2});
        end

        // Maximum count: 16383 instructions load addresses 0..16382.
        apply_reset();
        send(hdr(4'd1, 0, 16383), 0);
        for (int i = 0; i < 16383; i++) begin
            w = 32'(i + 1);
            send(w, 0);
        end
        idle(5);
        check("t7_ilog_n", ilog.size(), 16383);
        if (ilog.size() == 16383) begin
            check("t7_first", ilog[0], {14'd0, 32'd1});
            check("t7_last", ilog[16382], {14'd16382, 32'd16383});
        end
        check("t7_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
